// File: rtl/pc_branch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_branch_pkg : op encodings and op width shared by the PC unit    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pc_branch_pkg;

   localparam int c_op_w = 3;

   typedef enum logic [c_op_w-1:0] {
      OP_SEQ  = 3'd0,
      OP_BR   = 3'd1,
      OP_JMP  = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4
   } op_e;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ras_stack : circular-buffer return-address stack, push/pop/count   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_data,
   output logic [WIDTH-1:0]             o_top,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    w_ptr_inc;
   logic [PW-1:0]    w_ptr_dec;

   always_comb begin
      w_ptr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      w_ptr_dec = (r_wr_ptr == '0) ? PW'(DEPTH - 1) : r_wr_ptr - PW'(1);
   end

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_top   = r_mem[w_ptr_dec];

   // When full, the write slot is the oldest entry, so a push overwrites it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_push) begin
         r_wr_ptr <= w_ptr_inc;
         if (!o_full) r_count <= r_count + CW'(1);
      end else if (i_pop && !o_empty) begin
         r_wr_ptr <= w_ptr_dec;
         r_count  <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_branch_unit : PC sequencer with branch/jump/call/return and RAS |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_branch_unit
   import pc_branch_pkg::*;
#(
   parameter int                         INST_1_WIDTH    = 8,
   parameter int                         INST_2_WIDTH    = 12,
   parameter int                         INST_ADDR_WIDTH = 16,
   parameter int                         RAS_DEPTH       = 4,
   parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en,
   input  logic [c_op_w-1:0]                  op,
   input  logic                               cond,
   input  logic [INST_1_WIDTH-1:0]            inst_1,
   input  logic [INST_2_WIDTH-1:0]            inst_2,
   output logic [INST_ADDR_WIDTH-1:0]         pc,
   output logic                               taken,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
   output logic                               ras_ovf,
   output logic                               ras_unf,
   output logic                               illegal_op
);

   localparam int AW = INST_ADDR_WIDTH;

   logic [AW-1:0] r_pc;
   logic          r_taken;
   logic          r_ovf;
   logic          r_unf;
   logic          r_ill;

   op_e           w_op;
   logic [AW-1:0] w_pc_inc;
   logic [AW-1:0] w_offset;
   logic [AW-1:0] w_target;
   logic [AW-1:0] w_next_pc;
   logic          w_taken;
   logic          w_ovf;
   logic          w_unf;
   logic          w_ill;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_top;
   logic          w_full;
   logic          w_empty;

   assign w_op     = op_e'(op);
   assign w_pc_inc = r_pc + AW'(1);
   assign w_offset = AW'($signed(inst_2));
   assign w_target = AW'({inst_1, inst_2});

   always_comb begin
      w_next_pc = w_pc_inc;
      w_taken   = 1'b0;
      w_ovf     = 1'b0;
      w_unf     = 1'b0;
      w_ill     = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      case (w_op)
         OP_SEQ: ;
         OP_BR: begin
            if (cond) begin
               w_next_pc = r_pc + w_offset;
               w_taken   = 1'b1;
            end
         end
         OP_JMP: begin
            w_next_pc = w_target;
            w_taken   = 1'b1;
         end
         OP_CALL: begin
            w_next_pc = w_target;
            w_taken   = 1'b1;
            w_push    = en;
            w_ovf     = w_full;
         end
         OP_RET: begin
            if (!w_empty) begin
               w_next_pc = w_top;
               w_taken   = 1'b1;
               w_pop     = en;
            end else begin
               w_unf     = 1'b1;
            end
         end
         default: w_ill = 1'b1;
      endcase
   end

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (AW)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pc_inc),
      .o_top   (w_top),
      .o_count (ras_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A stalled cycle holds the PC but still clears every pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_taken <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_ill   <= 1'b0;
      end else if (en) begin
         r_pc    <= w_next_pc;
         r_taken <= w_taken;
         r_ovf   <= w_ovf;
         r_unf   <= w_unf;
         r_ill   <= w_ill;
      end else begin
         r_taken <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_ill   <= 1'b0;
      end
   end

   assign pc         = r_pc;
   assign taken      = r_taken;
   assign ras_ovf    = r_ovf;
   assign ras_unf    = r_unf;
   assign illegal_op = r_ill;

endmodule
`default_nettype wire
